andpp_seq_mult: RTL and testbench
=================================

ANDPP_SEQ_MULT -- requirements
Module: andpp_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands; registered.
REQ-006 SHALL have port a  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port b  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  product valid; registered.
REQ-009 SHALL have port out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port p  output  2*WIDTH  unsigned product a*b; registered.
REQ-011 SHALL have port busy  output  1  high in RUN state; registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; one state active at a time.
REQ-013 SHALL accept operands in IDLE on an edge where in_valid && in_ready; captures a, b; clears accumulator and bit counter; enters RUN; in_ready drops on that edge.
REQ-014 SHALL ignore in_valid while in_ready is low; a/b changes outside the accept edge have no effect.
REQ-015 SHALL in RUN, each edge, add partial product (a_reg AND {WIDTH{b_reg[cnt]}}) shifted left by cnt to the 2*WIDTH-bit accumulator, then increment cnt.
REQ-016 SHALL never overflow: accumulator is 2*WIDTH bits; no truncation of any partial product.
REQ-017 SHALL, without the REQ-027 feature, spend exactly WIDTH edges in RUN; out_valid rises and p is loaded at accept edge + WIDTH.
REQ-018 SHALL hold p and out_valid stable in DONE until the edge where out_valid && out_ready.
REQ-019 SHALL on the DONE handshake edge clear out_valid, return to IDLE and set in_ready on the same edge.
REQ-020 SHALL not accept new operands in RUN or DONE (in_ready = 0); back-to-back throughput is one product per WIDTH+2 edges minimum.
REQ-021 SHALL keep p at last product in IDLE; p changes only at RUN->DONE.
REQ-022 SHALL produce p = 0 for a = 0 or b = 0 with the same latency as any other operand (unless REQ-027 shortens it).

Reset
REQ-023 SHALL on rst_n low, asynchronously: state IDLE, in_ready 0, out_valid 0, busy 0, p 0, accumulator 0, cnt 0, operand registers 0.
REQ-024 SHALL assert in_ready on the first rising clk edge after rst_n deasserts.
REQ-025 SHALL abort any RUN or DONE transaction when rst_n asserts mid-operation; no out_valid for the aborted operands after release.

Configuration
REQ-026 SHALL use macro ANDPP_ZERO_SKIP_EN to select early termination.
REQ-027 SHALL, with ANDPP_ZERO_SKIP_EN defined, leave RUN after the edge processing the highest set bit of b_reg (remaining bits all zero); RUN length = index of msb set + 1, minimum 1 edge when b = 0; result identical.
REQ-028 SHALL, without ANDPP_ZERO_SKIP_EN, behave exactly per REQ-017 with fixed WIDTH-edge RUN.

Verification (WIDTH = 4)
REQ-029 SHALL cover: reset release -> in_ready 0 then 1 at first edge; out_valid 0, p 0.
REQ-030 SHALL cover: a=15, b=15 accepted at edge T -> busy high T..T+3, out_valid and p=225 at T+4 (macro undefined).
REQ-031 SHALL cover: a=9, b=0 -> p=0, out_valid at T+4 (undefined) / T+1 (ANDPP_ZERO_SKIP_EN defined).
REQ-032 SHALL cover: a=7, b=1 with ANDPP_ZERO_SKIP_EN -> p=7 at T+1; a=7, b=8 -> p=56 at T+4.
REQ-033 SHALL cover: a=13, b=11 with out_ready held low 5 cycles -> p=143, out_valid stay stable; in_ready 0 until handshake edge, then 1.
REQ-034 SHALL cover: rst_n pulsed low at T+2 of a=12, b=5 transaction -> all outputs reset immediately; no product 60 emitted; next operands a=3, b=3 give p=9.

Source files
------------

// File: rtl/andpp_seq_mult.sv
// andpp_seq_mult: sequential AND-partial-product unsigned multiplier, one multiplier bit per clock
//   Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b accept an operand pair;
//   out_valid/out_ready/p deliver the 2*WIDTH-bit product; busy is high while multiplying.
//   Option: define ANDPP_ZERO_SKIP_EN to end the run after the highest set bit of b.
module andpp_seq_mult #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, p_q, p_d, pp, sum;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d, last;
   assign pp  = {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[cnt_q]}}} << cnt_q;
   assign sum = acc_q + pp;
`ifdef ANDPP_ZERO_SKIP_EN
   // finish once no set bits remain above the one just processed
   assign last = ((b_q >> cnt_q) >> 1) == '0;
`else
   assign last = cnt_q == CW'(WIDTH - 1);
`endif
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      p_d         = p_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               state_d    = RUN;
               a_d        = a;
               b_d        = b;
               acc_d      = '0;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d     = DONE;
               p_d         = sum;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         p_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign p         = p_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_andpp_seq_mult.sv
// tb_andpp_seq_mult: randomized self-checking bench for andpp_seq_mult against a timeline model
module tb_andpp_seq_mult;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic       in_ready, out_valid, busy;
   logic [7:0] p;
   int         n_pass = 0, n_total = 0;
   int         cyc = 0, t_acc = 0, m_lat = 0;
   logic       m_in_ready, m_out_valid, m_busy;
   logic [7:0] m_p, m_prod;
   andpp_seq_mult #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask
   function automatic int lat_of(input logic [3:0] bv);
      int l;
`ifdef ANDPP_ZERO_SKIP_EN
      l = 1;
      for (int i = 0; i < 4; i++) if (bv[i]) l = i + 1;
`else
      l = 4;
`endif
      return l;
   endfunction
   // Timeline model: an accepted pair yields its product lat_of(b) edges after the accept edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_in_ready  <= 1'b0;
         m_out_valid <= 1'b0;
         m_busy      <= 1'b0;
         m_p         <= '0;
      end else begin
         cyc <= cyc + 1;
         if (m_out_valid) begin
            if (out_ready) begin
               m_out_valid <= 1'b0;
               m_in_ready  <= 1'b1;
            end
         end else if (m_busy) begin
            if (cyc == t_acc + m_lat) begin
               m_busy      <= 1'b0;
               m_out_valid <= 1'b1;
               m_p         <= m_prod;
            end
         end else if (m_in_ready) begin
            if (in_valid) begin
               m_in_ready <= 1'b0;
               m_busy     <= 1'b1;
               t_acc      <= cyc;
               m_lat      <= lat_of(b);
               m_prod     <= 8'(int'(a) * int'(b));
            end
         end else m_in_ready <= 1'b1;
      end
   end
   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(m_in_ready));
      chk("out_valid", int'(out_valid), int'(m_out_valid));
      chk("busy", int'(busy), int'(m_busy));
      chk("p", int'(p), int'(m_p));
   end
   task automatic op(input logic [3:0] ai, input logic [3:0] bi, input int hold,
                     input int ep, input int el, input logic noisy);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      chk("ready_wait", int'(in_ready), 1);
      a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 50) begin
         if (noisy) begin in_valid = 1'($urandom); a = 4'($urandom); b = 4'($urandom); end
         @(negedge clk);
         k++;
      end
      chk("latency", k, el);
      chk("product", int'(p), ep);
      for (int i = 0; i < hold; i++) begin
         if (noisy) begin in_valid = 1'($urandom); a = 4'($urandom); b = 4'($urandom); end
         @(negedge clk);
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_p", int'(p), ep);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("handshake_ready", int'(in_ready), 1);
      chk("handshake_valid", int'(out_valid), 0);
   endtask
   initial begin
      logic [3:0] ra, rb;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_p", int'(p), 0);
      rst_n = 1'b1;
      #1 chk("release_in_ready", int'(in_ready), 0);
      chk("release_out_valid", int'(out_valid), 0);
      @(negedge clk);
      chk("first_edge_in_ready", int'(in_ready), 1);
      op(4'd15, 4'd15, 0, 225, 4, 1'b0);
      chk("model_p_225", int'(m_p), 225);
`ifdef ANDPP_ZERO_SKIP_EN
      op(4'd9, 4'd0, 0, 0, 1, 1'b0);
      op(4'd7, 4'd1, 0, 7, 1, 1'b0);
`else
      op(4'd9, 4'd0, 0, 0, 4, 1'b0);
      op(4'd7, 4'd1, 0, 7, 4, 1'b0);
`endif
      op(4'd7, 4'd8, 0, 56, 4, 1'b0);
      op(4'd13, 4'd11, 5, 143, 4, 1'b1);
      chk("model_p_143", int'(m_p), 143);
      // abort a 12*5 transaction two edges after accept
      a = 4'd12; b = 4'd5; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("abort_busy", int'(busy), 0);
      chk("abort_p", int'(p), 0);
      chk("abort_in_ready", int'(in_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_valid", int'(out_valid), 0);
      end
`ifdef ANDPP_ZERO_SKIP_EN
      op(4'd3, 4'd3, 0, 9, 2, 1'b0);
`else
      op(4'd3, 4'd3, 0, 9, 4, 1'b0);
`endif
      for (int i = 0; i < 40; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         op(ra, rb, int'($urandom_range(0, 3)), int'(ra) * int'(rb), lat_of(rb), 1'b1);
      end
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
